// File: rtl/mux_pkg.sv
// Shared constants and helpers for the scanning registered multiplexer.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;
    localparam logic G_ON        = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Channel data, select and output bundle between sample sources and mux_scan.
interface mux_scan_if import mux_pkg::*; #(
    parameter int N = 4,
    parameter int W = 1,
    localparam int SW = clog2(N)
);
    // No backpressure: G low qualifies every rising edge as a transfer, and
    // VALID marks the cycles where Y carries a real channel sample.
    logic          G;
    logic          MODE;
    logic [SW-1:0] C;
    logic [N*W-1:0] X;
    logic [W-1:0]  Y;
    logic [SW-1:0] CH;
    logic          VALID;
    logic          WRAP;

    modport master (output G, MODE, C, X, input Y, CH, VALID, WRAP);
    modport slave  (input G, MODE, C, X, output Y, CH, VALID, WRAP);

endinterface

// File: rtl/mux_scan_ctr.sv
// Scan pointer and dwell counter; wrap pulses with the last sample of channel N-1.
module mux_scan_ctr import mux_pkg::*; #(
    parameter int N = 4,
    parameter int DWELL = 1,
    localparam int SW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          load,
    input  logic [SW-1:0] load_val,
    output logic [SW-1:0] sp,
    output logic          wrap
);

    localparam int DCW = clog2(DWELL + 1);
    localparam logic [DCW-1:0] DC_LAST = DCW'(DWELL - 1);
    localparam logic [SW-1:0]  SP_LAST = SW'(N - 1);

    logic [SW-1:0]  sp_q, sp_d;
    logic [DCW-1:0] dc_q, dc_d;
    logic           wrap_q, wrap_d;

    always_comb begin
        sp_d   = sp_q;
        dc_d   = dc_q;
        wrap_d = 1'b0;
        if (load) begin
            // Out-of-range manual selects park the pointer on the last channel.
            sp_d = (load_val > SP_LAST) ? SP_LAST : load_val;
            dc_d = '0;
        end else if (en) begin
            if (dc_q == DC_LAST) begin
                dc_d = '0;
                if (sp_q == SP_LAST) begin
                    sp_d   = '0;
                    wrap_d = 1'b1;
                end else begin
                    sp_d = sp_q + 1'b1;
                end
            end else begin
                dc_d = dc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q   <= '0;
            dc_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dc_q   <= dc_d;
            wrap_q <= wrap_d;
        end
    end

    assign sp   = sp_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/mux_scan.sv
// N-channel registered mux with manual select or timed auto-scan.
module mux_scan import mux_pkg::*; #(
    parameter int N = 4,
    parameter int W = 1,
    parameter int DWELL = 1
) (
    input logic       CLK,
    input logic       RST,
    mux_scan_if.slave bus
);

    localparam int SW = clog2(N);

    logic          auto_en, load_en;
    logic [SW-1:0] sp;
    logic          ctr_wrap;
    logic [SW-1:0] sel;
    logic [W-1:0]  y_sel;
    logic          hit;

    logic [W-1:0]  y_q, y_d;
    logic [SW-1:0] ch_q, ch_d;
    logic          valid_q, valid_d;

    assign auto_en = (bus.G == G_ON) && (bus.MODE == MODE_AUTO);
    assign load_en = (bus.G == G_ON) && (bus.MODE == MODE_MANUAL);

    mux_scan_ctr #(.N(N), .DWELL(DWELL)) u_ctr (
        .clk      (CLK),
        .rst      (RST),
        .en       (auto_en),
        .load     (load_en),
        .load_val (bus.C),
        .sp       (sp),
        .wrap     (ctr_wrap)
    );

    always_comb begin
        sel     = auto_en ? sp : bus.C;
        y_sel   = '0;
        hit     = 1'b0;
        // A select past N-1 matches no channel and yields an invalid zero sample.
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) begin
                y_sel = bus.X[k*W +: W];
                hit   = 1'b1;
            end
        end
        y_d     = '0;
        ch_d    = ch_q;
        valid_d = 1'b0;
        if (bus.G == G_ON) begin
            ch_d = sel;
            if (hit) begin
                y_d     = y_sel;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            y_q     <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Y     = y_q;
    assign bus.CH    = ch_q;
    assign bus.VALID = valid_q;
    assign bus.WRAP  = ctr_wrap;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: three builds (4x8 dwell 2, 3x4 dwell 2, 4x8 dwell 1) against a sequence model.
module tb_mux_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        g_v    [3];
    logic        mode_v [3];
    logic [1:0]  c_v    [3];
    logic [31:0] x_v    [3];

    int pn [3] = '{4, 3, 4};
    int pd [3] = '{2, 2, 1};
    int pw [3] = '{8, 4, 8};

    int m_start [3];
    int m_t     [3];
    int m_ch    [3];

    logic [11:0] exp_now [3];
    logic [11:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    mux_scan_if #(.N(4), .W(8)) bus_a ();
    mux_scan_if #(.N(3), .W(4)) bus_b ();
    mux_scan_if #(.N(4), .W(8)) bus_c ();

    assign bus_a.G = g_v[0];
    assign bus_a.MODE = mode_v[0];
    assign bus_a.C = c_v[0];
    assign bus_a.X = x_v[0];
    assign bus_b.G = g_v[1];
    assign bus_b.MODE = mode_v[1];
    assign bus_b.C = c_v[1];
    assign bus_b.X = x_v[1][11:0];
    assign bus_c.G = g_v[2];
    assign bus_c.MODE = mode_v[2];
    assign bus_c.C = c_v[2];
    assign bus_c.X = x_v[2];

    mux_scan #(.N(4), .W(8), .DWELL(2)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
    mux_scan #(.N(3), .W(4), .DWELL(2)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));
    mux_scan #(.N(4), .W(8), .DWELL(1)) dut_c (.CLK(clk), .RST(rst), .bus(bus_c));

    // Observed outputs packed as {Y(8), CH(2), VALID, WRAP}.
    function automatic logic [11:0] obs(input int id);
        case (id)
            0:       return {bus_a.Y, bus_a.CH, bus_a.VALID, bus_a.WRAP};
            1:       return {4'h0, bus_b.Y, bus_b.CH, bus_b.VALID, bus_b.WRAP};
            default: return {bus_c.Y, bus_c.CH, bus_c.VALID, bus_c.WRAP};
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_start[i] = 0;
            m_t[i]     = 0;
            m_ch[i]    = 0;
        end
    endfunction

    // Auto-scan output is channel (start + t/DWELL) mod N, t = enabled auto edges since the last manual load.
    function automatic logic [11:0] model_step(input int id);
        int n, d, w, ch, yv;
        logic v, wr;
        n = pn[id];
        d = pd[id];
        w = pw[id];
        if (g_v[id]) return {8'h00, 2'(m_ch[id]), 2'b00};
        if (!mode_v[id]) begin
            ch = int'(c_v[id]);
            v  = (ch < n);
            yv = v ? int'((x_v[id] >> (ch * w)) & ((32'd1 << w) - 1)) : 0;
            wr = 1'b0;
            m_start[id] = (ch > n - 1) ? n - 1 : ch;
            m_t[id] = 0;
        end else begin
            ch = (m_start[id] + m_t[id] / d) % n;
            v  = 1'b1;
            yv = int'((x_v[id] >> (ch * w)) & ((32'd1 << w) - 1));
            wr = ((m_t[id] % d) == d - 1) && (ch == n - 1);
            m_t[id]++;
        end
        m_ch[id] = ch;
        return {8'(yv), 2'(ch), v, wr};
    endfunction

    task automatic clock_edge();
        for (int i = 0; i < 3; i++) exp_now[i] = model_step(i);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_edge(input int id, input logic g, input logic mode, input logic [1:0] c);
        g_v[id] = g;
        mode_v[id] = mode;
        c_v[id] = c;
        clock_edge();
        exp_q.push_back(exp_now[id]);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        repeat (2) @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            got = obs(id);
            checks++;
            if (got !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %h expected %h", id, got, 12'h000);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_manual();
        logic [11:0] got, e;
        drive_edge(0, 1'b0, 1'b0, 2'd2);
        got = obs(0);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL manual_c2: got %h expected %h", got, e);
        end
        checks++;
        if (got !== {8'h33, 2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL manual_c2_lit: got %h expected %h", got, {8'h33, 2'd2, 1'b1, 1'b0});
        end
        drive_edge(0, 1'b0, 1'b0, 2'd1);
        got = obs(0);
        e = exp_q.pop_front();
        checks++;
        if (got !== e || got[11:4] !== 8'h22) begin
            errors++;
            $display("FAIL manual_c1: got %h expected %h", got, e);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        got = obs(0);
        checks++;
        if (got !== 12'h000) begin
            errors++;
            $display("FAIL manual_async_reset: got %h expected %h", got, 12'h000);
        end
        g_v[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_auto_scan();
        logic [7:0] y_t [9] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h11};
        logic [11:0] got, e;
        pulse_reset();
        for (int i = 0; i < 9; i++) begin
            drive_edge(0, 1'b0, 1'b1, 2'd0);
            got = obs(0);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL auto_scan[%0d]: got %h expected %h", i, got, e);
            end
            checks++;
            if (got[11:4] !== y_t[i] || got[1] !== 1'b1 || got[0] !== (i == 7)) begin
                errors++;
                $display("FAIL auto_scan_lit[%0d]: got y=%h v=%b w=%b expected y=%h v=1 w=%b",
                         i, got[11:4], got[1], got[0], y_t[i], (i == 7));
            end
        end
        g_v[0] = 1'b1;
    endtask

    task automatic test_pause();
        logic       g_t [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] y_t [8] = '{8'h11, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h22, 8'h33};
        logic [11:0] got, e;
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            drive_edge(0, g_t[i], 1'b1, 2'd0);
            got = obs(0);
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pause[%0d]: got %h expected %h", i, got, e);
            end
            checks++;
            if (got[11:4] !== y_t[i] || got[1] !== !g_t[i]) begin
                errors++;
                $display("FAIL pause_lit[%0d]: got y=%h v=%b expected y=%h v=%b",
                         i, got[11:4], got[1], y_t[i], !g_t[i]);
            end
        end
        g_v[0] = 1'b1;
    endtask

    task automatic test_mode_switch();
        logic       mode_t [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] c_t    [6] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [7:0] y_t    [6] = '{8'h44, 8'h44, 8'h44, 8'h11, 8'h11, 8'h11};
        logic [1:0] ch_t   [6] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
        logic [11:0] got, e, lit;
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            drive_edge(0, 1'b0, mode_t[i], c_t[i]);
            got = obs(0);
            e = exp_q.pop_front();
            lit = {y_t[i], ch_t[i], 1'b1, (i == 2)};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mode_switch[%0d]: got %h expected %h", i, got, e);
            end
            checks++;
            if (got !== lit) begin
                errors++;
                $display("FAIL mode_switch_lit[%0d]: got %h expected %h", i, got, lit);
            end
        end
        g_v[0] = 1'b1;
    endtask

    task automatic test_non_pow2();
        logic [1:0] ch_t [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
        logic [11:0] got, e, lit;
        pulse_reset();
        drive_edge(1, 1'b0, 1'b0, 2'd3);
        got = obs(1);
        e = exp_q.pop_front();
        checks++;
        if (got !== e || got !== {8'h00, 2'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL np2_manual_c3: got %h expected %h", got, e);
        end
        // Saturated pointer: scan starts on channel 2 and wraps after its dwell.
        for (int i = 0; i < 2; i++) begin
            drive_edge(1, 1'b0, 1'b1, 2'd0);
            got = obs(1);
            e = exp_q.pop_front();
            lit = {8'h03, 2'd2, 1'b1, (i == 1)};
            checks++;
            if (got !== e || got !== lit) begin
                errors++;
                $display("FAIL np2_saturate[%0d]: got %h expected %h", i, got, lit);
            end
        end
        g_v[1] = 1'b1;
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            drive_edge(1, 1'b0, 1'b1, 2'd0);
            got = obs(1);
            e = exp_q.pop_front();
            lit = {4'h0, 4'(ch_t[i] + 2'd1), ch_t[i], 1'b1, (i == 5)};
            checks++;
            if (got !== e || got !== lit) begin
                errors++;
                $display("FAIL np2_scan[%0d]: got %h expected %h model %h", i, got, lit, e);
            end
        end
        g_v[1] = 1'b1;
    endtask

    task automatic test_dwell1();
        logic [7:0] y_t [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [11:0] got, e, lit;
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            drive_edge(2, 1'b0, 1'b1, 2'd0);
            got = obs(2);
            e = exp_q.pop_front();
            lit = {y_t[i % 4], 2'(i % 4), 1'b1, ((i % 4) == 3)};
            checks++;
            if (got !== e || got !== lit) begin
                errors++;
                $display("FAIL dwell1[%0d]: got %h expected %h model %h", i, got, lit, e);
            end
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        got = obs(2);
        checks++;
        if (got !== 12'h000) begin
            errors++;
            $display("FAIL dwell1_async_reset: got %h expected %h", got, 12'h000);
        end
        g_v[2] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [11:0] got, e;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 49) == 0) pulse_reset();
            for (int id = 0; id < 3; id++) begin
                g_v[id]    = ($urandom_range(0, 3) == 0);
                mode_v[id] = 1'($urandom_range(0, 1));
                c_v[id]    = 2'($urandom_range(0, 3));
                x_v[id]    = $urandom;
            end
            clock_edge();
            for (int id = 0; id < 3; id++) exp_q.push_back(exp_now[id]);
            for (int id = 0; id < 3; id++) begin
                got = obs(id);
                e = exp_q.pop_front();
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL random[%0d] dut%0d: got %h expected %h", it, id, got, e);
                end
            end
        end
        for (int id = 0; id < 3; id++) g_v[id] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            g_v[i]    = 1'b1;
            mode_v[i] = 1'b0;
            c_v[i]    = 2'd0;
        end
        x_v[0] = 32'h4433_2211;
        x_v[1] = 32'h0000_0321;
        x_v[2] = 32'h4433_2211;
        rst = 1'b1;
        model_reset();
        test_reset();
        test_manual();
        test_auto_scan();
        test_pause();
        test_mode_switch();
        test_non_pow2();
        test_dwell1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
